// File: rtl/wide_add_pkg.sv
// Shared types and sizing for the sequential wide adder: FSM state encoding,
// default operand/slice widths and the slice-count helper.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int calcNchunk(input int width, input int chunkW);
    return width / chunkW;
  endfunction

  localparam int DEF_WIDTH   = 1024;
  localparam int DEF_CHUNK_W = 64;
  localparam int DEF_NCHUNK  = calcNchunk(DEF_WIDTH, DEF_CHUNK_W);

endpackage

// File: rtl/chunk_adder.sv
// CHUNK_W-bit ripple-carry adder built from per-bit full adders; one instance
// is time-shared across every slice of the wide operands.
module chunk_adder
  import wide_add_pkg::*;
#(
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               cin,
  output logic [CHUNK_W-1:0] sum,
  output logic               cout
);

  // Carry walks through a local variable so the chain is one combinational path.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/wide_add_seq_ctrl.sv
// Sequential WIDTH-bit adder that processes one CHUNK_W slice per clock.
// Define WIDE_ADD_SUB_EN to honour op=1 as a two's-complement subtract.
module wide_add_seq_ctrl
  import wide_add_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             busy
);

  localparam int NCHUNK = calcNchunk(WIDTH, CHUNK_W);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t               r_state;
  state_t               w_nextState;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_carry;
  logic                 r_carryOut;
  logic [WIDTH-1:0]     r_opA;
  logic [WIDTH-1:0]     r_opB;
  logic [CHUNK_W-1:0]   r_outChunk [NCHUNK];
  logic [CHUNK_W-1:0]   w_sliceA   [NCHUNK];
  logic [CHUNK_W-1:0]   w_sliceB   [NCHUNK];
  logic [CHUNK_W-1:0]   w_sum;
  logic                 w_cout;
  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH-1:0]     w_bIn;
  logic                 w_cinIn;

`ifdef WIDE_ADD_SUB_EN
  assign w_bIn   = op ? ~in2 : in2;
  assign w_cinIn = op;
`else
  logic w_unusedOp;
  assign w_unusedOp = op;
  assign w_bIn      = in2;
  assign w_cinIn    = 1'b0;
`endif

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_idx == IDX_W'(NCHUNK - 1));
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign carry_out = r_carryOut;

  genvar g;
  generate
    for (g = 0; g < NCHUNK; g++) begin : gSlice
      assign w_sliceA[g]                  = r_opA[g*CHUNK_W +: CHUNK_W];
      assign w_sliceB[g]                  = r_opB[g*CHUNK_W +: CHUNK_W];
      assign out[g*CHUNK_W +: CHUNK_W]    = r_outChunk[g];
    end
  endgenerate

  chunk_adder #(
    .CHUNK_W(CHUNK_W)
  ) uChunkAdder (
    .a   (w_sliceA[r_idx]),
    .b   (w_sliceB[r_idx]),
    .cin (r_carry),
    .sum (w_sum),
    .cout(w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_nextState = RUN;
      RUN:     if (w_last)    w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default:                w_nextState = IDLE;
    endcase
  end

  // Operands are only meaningful once accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_opA <= in1;
      r_opB <= w_bIn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_carryOut <= 1'b0;
      for (int i = 0; i < NCHUNK; i++) r_outChunk[i] <= '0;
    end else if (w_accept) begin
      r_idx   <= '0;
      r_carry <= w_cinIn;
    end else if (r_state == RUN) begin
      r_outChunk[r_idx] <= w_sum;
      r_carry           <= w_cout;
      r_idx             <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) r_carryOut <= w_cout;
    end
  end

endmodule

// File: tb/tb_wide_add_seq_ctrl.sv
// Directed self-checking bench for wide_add_seq_ctrl at default parameters;
// expected results follow WIDE_ADD_SUB_EN when it is defined.
module tb_wide_add_seq_ctrl;

  localparam int W = 1024;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry_out;
  logic         busy;

  int           total;
  int           bad;
  int           lat;
  logic [W-1:0] expVal;
  logic [W-1:0] allOnes;

  wide_add_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in1      (in1),
    .in2      (in2),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .carry_out(carry_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed hi=%h lo=%h expected hi=%h lo=%h",
             tag, obs[W-1 -: 64], obs[127:0], exp[W-1 -: 64], exp[127:0]);
    end
  endtask

  // Present one request, let it be accepted, then count edges until out_valid.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic o, output int latency);
    in1      = a;
    in2      = b;
    op       = o;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    latency  = 0;
    while (!out_valid && latency < 40) begin
      tick();
      latency++;
    end
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    allOnes   = '1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in1       = '0;
    in2       = '0;
    op        = 1'b0;

    repeat (3) tick();
    checkOutput("rst_in_ready", W'(in_ready), W'(1));
    checkOutput("rst_out_valid", W'(out_valid), W'(0));
    checkOutput("rst_busy", W'(busy), W'(0));
    checkOutput("rst_out", out, '0);
    checkOutput("rst_carry_out", W'(carry_out), W'(0));
    rst_n = 1'b1;
    tick();

    $display("[TB] all-ones + 1");
    in1 = allOnes; in2 = W'(1); op = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("run_busy", W'(busy), W'(1));
    checkOutput("run_in_ready", W'(in_ready), W'(0));
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("wrap_latency", W'(lat), W'(16));
    checkOutput("wrap_out", out, '0);
    checkOutput("wrap_carry", W'(carry_out), W'(1));
    releaseResult();
    checkOutput("rel_out_valid", W'(out_valid), W'(0));
    checkOutput("rel_in_ready", W'(in_ready), W'(1));
    checkOutput("rel_out_kept", out, '0);
    checkOutput("rel_carry_kept", W'(carry_out), W'(1));

    $display("[TB] chunk0 to chunk1 carry");
    expVal = '0; expVal[64] = 1'b1;
    applyStimulus(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, lat);
    checkOutput("c01_latency", W'(lat), W'(16));
    checkOutput("c01_out", out, expVal);
    checkOutput("c01_carry", W'(carry_out), W'(0));
    releaseResult();

    $display("[TB] carry ripples through every chunk boundary");
    applyStimulus({16{64'h8000_0000_0000_0000}}, {16{64'h8000_0000_0000_0000}}, 1'b0, lat);
    checkOutput("rip_out", out, {{15{64'h1}}, 64'h0});
    checkOutput("rip_carry", W'(carry_out), W'(1));
    releaseResult();

    $display("[TB] 5 op=1 7");
    applyStimulus(W'(5), W'(7), 1'b1, lat);
`ifdef WIDE_ADD_SUB_EN
    expVal = allOnes - W'(1);
`else
    expVal = W'(12);
`endif
    checkOutput("op1_out", out, expVal);
    checkOutput("op1_carry", W'(carry_out), W'(0));
    releaseResult();

    $display("[TB] hold in DONE with in_valid asserted");
    applyStimulus(W'(100), W'(200), 1'b0, lat);
    in1 = W'(1); in2 = W'(1); op = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("hold_out_valid", W'(out_valid), W'(1));
      checkOutput("hold_out", out, W'(300));
      checkOutput("hold_carry", W'(carry_out), W'(0));
      checkOutput("hold_in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("hold_rel_idle", W'(in_ready), W'(1));
    checkOutput("hold_rel_busy", W'(busy), W'(0));
    checkOutput("hold_rel_out", out, W'(300));
    tick();
    in_valid = 1'b0;
    checkOutput("next_accept_busy", W'(busy), W'(1));
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("next_latency", W'(lat), W'(16));
    checkOutput("next_out", out, W'(2));
    releaseResult();

    $display("[TB] reset pulse at idx 8");
    in1 = allOnes; in2 = allOnes; op = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_in_ready", W'(in_ready), W'(1));
    checkOutput("midrst_out_valid", W'(out_valid), W'(0));
    checkOutput("midrst_busy", W'(busy), W'(0));
    checkOutput("midrst_out", out, '0);
    checkOutput("midrst_carry", W'(carry_out), W'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    checkOutput("postrst_no_valid", W'(out_valid), W'(0));
    checkOutput("postrst_out", out, '0);
    applyStimulus(W'(3), W'(4), 1'b0, lat);
    checkOutput("postrst_latency", W'(lat), W'(16));
    checkOutput("postrst_sum", out, W'(7));
    checkOutput("postrst_carry", W'(carry_out), W'(0));
    releaseResult();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wide_add_seq_ctrl.md
WIDE_ADD_SEQ_CTRL -- requirements
Module: wide_add_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 1024, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK_W, default 64, adder-slice width; WIDTH SHALL be an integer multiple of CHUNK_W; NCHUNK = WIDTH/CHUNK_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port in1  input  WIDTH  first operand.
REQ-008 SHALL have port in2  input  WIDTH  second operand.
REQ-009 SHALL have port op  input  1  0 = add, 1 = subtract (see REQ-030).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out  output  WIDTH  registered result.
REQ-013 SHALL have port carry_out  output  1  carry from the top chunk.
REQ-014 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in all other states, it SHALL be 0.
REQ-017 On an edge with in_valid=1 and in_ready=1: SHALL capture in1, in2, op; set chunk index to 0; load carry register with carry-in (0 for add); go to RUN.
REQ-018 Each RUN edge SHALL add chunk[idx] of both operands plus the carry register in the slice, write the sum into out[idx*CHUNK_W +: CHUNK_W], store the slice carry, and increment idx.
REQ-019 On the RUN edge processing idx = NCHUNK-1, SHALL set carry_out to the slice carry, go to DONE, and assert out_valid.
REQ-020 Latency SHALL be exactly NCHUNK edges from the accept edge to out_valid=1 (16 at defaults).
REQ-021 In DONE, out, carry_out, and out_valid SHALL be held stable until an edge with out_ready=1; that edge SHALL return to IDLE and clear out_valid. out and carry_out SHALL keep their values.
REQ-022 in_valid in RUN or DONE SHALL be ignored; no accept occurs in the DONE→IDLE edge even if in_valid=1.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; overflow SHALL be reported only via carry_out.
REQ-024 During RUN, out SHALL be partially updated; consumers SHALL use it only when out_valid=1.

Reset
REQ-025 rst_n=0 SHALL immediately force state to IDLE, idx to 0, carry register to 0, out to 0, carry_out to 0, out_valid to 0, and busy to 0; in_ready SHALL be 1.
REQ-026 Reset asserted mid-RUN or in DONE SHALL discard the transaction; no out_valid SHALL follow.
REQ-027 Operand capture registers need not be reset.

Configuration
REQ-028 SHALL provide macro WIDE_ADD_SUB_EN.
REQ-029 Without WIDE_ADD_SUB_EN: op SHALL be ignored, and every transaction SHALL be an addition.
REQ-030 With WIDE_ADD_SUB_EN: op=1 captured SHALL add in1 + ~in2 with carry-in 1 (two's-complement subtract); carry_out=1 SHALL mean no borrow.

Structure
REQ-031 Package wide_add_pkg SHALL hold the state enum, WIDTH and CHUNK_W defaults, and the NCHUNK computation.
REQ-032 SHALL instantiate exactly one sub-module, chunk_adder (CHUNK_W-bit ripple-carry of per-bit full adders, ports a, b, cin, sum, cout), shared by all chunks.

Verification
REQ-033 Reset: rst_n low → in_ready=1, out_valid=0, busy=0, out=0, carry_out=0.
REQ-034 in1=all-ones, in2=1, op=0 → out=0 and carry_out=1; out_valid rises exactly 16 edges after the accept.
REQ-035 in1=2^64-1, in2=1 → out=2^64 and carry_out=0, proving carry crossing from chunk 0 to chunk 1.
REQ-036 in1=5, in2=7, op=1: with WIDE_ADD_SUB_EN → out=2^1024-2, carry_out=0; without it → out=12, carry_out=0.
REQ-037 Hold out_ready=0 for 10 cycles in DONE while in_valid=1 → out_valid, out, and carry_out stay stable and in_ready=0; release → IDLE, then the next request is accepted.
REQ-038 Pulse rst_n low at idx=8 → all outputs reach reset values; a following 3+4 transaction → out=7 after 16 edges.
